// File: rtl/cp0_exc.sv
// CP0 register file with exception, interrupt and ERET bookkeeping.
// Bank 0 regs 12/13/14 are the dedicated Status/Cause/EPC registers.
// Every other (bank, reg) pair is plain general storage.
module cp0_exc #(
   parameter int unsigned      WIDTH   = 32,
   parameter int unsigned      SEL_W   = 3,
   parameter int unsigned      NUM_IRQ = 4,
   parameter logic [WIDTH-1:0] VECTOR  = WIDTH'(32'h0000_0080)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [4:0]         R_in,
   input  logic [4:0]         W_in,
   input  logic [SEL_W-1:0]   sel,
   input  logic [WIDTH-1:0]   Din,
   input  logic               WE,
   output logic [WIDTH-1:0]   R_out,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               exc_take,
   input  logic [4:0]         exc_code,
   input  logic [WIDTH-1:0]   exc_pc,
   input  logic               eret,
   output logic               int_req,
   output logic [WIDTH-1:0]   epc_out,
   output logic [WIDTH-1:0]   exc_vector
);

   localparam int unsigned NREG  = (2 ** SEL_W) * 32;
   localparam int unsigned IDX_W = SEL_W + 5;
   localparam logic [4:0]  REG_STATUS = 5'd12;
   localparam logic [4:0]  REG_CAUSE  = 5'd13;
   localparam logic [4:0]  REG_EPC    = 5'd14;

   logic [WIDTH-1:0]   gpr [NREG];

   logic               ie, ie_n;
   logic               exl, exl_n;
   logic [NUM_IRQ-1:0] im, im_n;
   logic [4:0]         cause_code, cause_code_n;
   logic [NUM_IRQ-1:0] ip, ip_n;
   logic [WIDTH-1:0]   epc, epc_n;
   logic [NUM_IRQ-1:0] irq_q, irq_qd;

   logic               bank0_w;
   logic               gpr_we;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] low_bit;
   logic [WIDTH-1:0]   status_rd;
   logic [WIDTH-1:0]   cause_rd;

   assign bank0_w = (sel == '0);
   assign gpr_we  = WE && !(bank0_w && (W_in >= REG_STATUS) && (W_in <= REG_EPC));

   // Pending-interrupt edge detect and lowest pending-and-enabled bit (x & -x).
   assign rise    = irq_q & ~irq_qd;
   assign pend    = ip & im;
   assign low_bit = pend & (~pend + NUM_IRQ'(1));

   // General storage: banks 1..N and bank-0 regs other than 12-14.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int unsigned i = 0; i < NREG; i++) gpr[i] <= '0;
      end else if (gpr_we) begin
         gpr[IDX_W'({sel, W_in})] <= Din;
      end
   end

   // Dedicated register state and the irq synchroniser/edge history.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ie         <= 1'b0;
         exl        <= 1'b0;
         im         <= '0;
         cause_code <= '0;
         ip         <= '0;
         epc        <= '0;
         irq_q      <= '0;
         irq_qd     <= '0;
      end else begin
         ie         <= ie_n;
         exl        <= exl_n;
         im         <= im_n;
         cause_code <= cause_code_n;
         ip         <= ip_n;
         epc        <= epc_n;
         irq_q      <= irq;
         irq_qd     <= irq_q;
      end
   end

   // Next dedicated state: MTC0 first, then exception/ERET fields override, irq set last.
   always_comb begin
      ie_n         = ie;
      exl_n        = exl;
      im_n         = im;
      cause_code_n = cause_code;
      ip_n         = ip;
      epc_n        = epc;
      if (WE && bank0_w) begin
         case (W_in)
            REG_STATUS: begin
               ie_n  = Din[0];
               exl_n = Din[1];
               im_n  = Din[8 +: NUM_IRQ];
            end
            REG_CAUSE: ip_n  = Din[8 +: NUM_IRQ];
            REG_EPC:   epc_n = Din;
            default: ;
         endcase
      end
      if (exc_take) begin
         epc_n        = exc_pc;
         exl_n        = 1'b1;
         cause_code_n = exc_code;
         if (exc_code == 5'd0) ip_n = ip_n & ~low_bit;
      end else if (eret) begin
         exl_n = 1'b0;
      end
      ip_n = ip_n | rise;
   end

   // Architectural views of Status and Cause; undefined bits read zero.
   always_comb begin
      status_rd               = '0;
      status_rd[0]            = ie;
      status_rd[1]            = exl;
      status_rd[8 +: NUM_IRQ] = im;
      cause_rd                = '0;
      cause_rd[6:2]           = cause_code;
      cause_rd[8 +: NUM_IRQ]  = ip;
   end

   // MFC0 read port.
   always_comb begin
      R_out = gpr[IDX_W'({sel, R_in})];
      if (sel == '0) begin
         case (R_in)
            REG_STATUS: R_out = status_rd;
            REG_CAUSE:  R_out = cause_rd;
            REG_EPC:    R_out = epc;
            default: ;
         endcase
      end
   end

   assign int_req    = ie & ~exl & (|(ip & im));
   assign epc_out    = epc;
   assign exc_vector = VECTOR;

endmodule

// File: tb/tb_cp0_exc.sv
// Randomised + directed scoreboard bench for cp0_exc against a behavioural model.
module tb_cp0_exc;

   logic        clk;
   logic        clr;
   logic [4:0]  R_in, W_in;
   logic [2:0]  sel;
   logic [31:0] Din;
   logic        WE;
   logic [31:0] R_out;
   logic [3:0]  irq;
   logic        exc_take;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        eret;
   logic        int_req;
   logic [31:0] epc_out;
   logic [31:0] exc_vector;

   cp0_exc dut (
      .clk(clk), .clr(clr), .R_in(R_in), .W_in(W_in), .sel(sel), .Din(Din), .WE(WE),
      .R_out(R_out), .irq(irq), .exc_take(exc_take), .exc_code(exc_code),
      .exc_pc(exc_pc), .eret(eret), .int_req(int_req), .epc_out(epc_out),
      .exc_vector(exc_vector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r_out;
      logic        int_req;
      logic [31:0] epc;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_no   = 0;

   // Behavioural model state (architectural view only).
   logic [31:0] m_mem [8][32];
   logic        m_ie, m_exl;
   logic [3:0]  m_im, m_ip;
   logic [4:0]  m_code;
   logic [31:0] m_epc;
   logic [3:0]  m_irq_q, m_irq_qd;
   logic [3:0]  g_irq;

   function automatic void model_zero();
      for (int b = 0; b < 8; b++)
         for (int r = 0; r < 32; r++) m_mem[b][r] = 32'h0;
      m_ie = 0; m_exl = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0;
      m_irq_q = 0; m_irq_qd = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] s, input logic [4:0] r);
      logic [31:0] v;
      v = 32'h0;
      if (s == 3'd0 && r == 5'd12) begin
         v[0] = m_ie; v[1] = m_exl; v[11:8] = m_im;
      end else if (s == 3'd0 && r == 5'd13) begin
         v[6:2] = m_code; v[11:8] = m_ip;
      end else if (s == 3'd0 && r == 5'd14) begin
         v = m_epc;
      end else begin
         v = m_mem[s][r];
      end
      return v;
   endfunction

   // One rising edge of the architecture, applying the rules in priority order.
   function automatic void model_edge(input logic c_clr, input logic c_we, input logic [2:0] c_sel,
                                      input logic [4:0] c_w, input logic [31:0] c_din,
                                      input logic [3:0] c_irq, input logic c_take,
                                      input logic [4:0] c_code, input logic [31:0] c_pc,
                                      input logic c_eret);
      logic [3:0] new_bits, n_ip;
      int         lowest;
      if (c_clr) begin
         model_zero();
         return;
      end
      new_bits = 4'h0;
      for (int i = 0; i < 4; i++) if (m_irq_q[i] && !m_irq_qd[i]) new_bits[i] = 1'b1;
      lowest = -1;
      for (int i = 0; i < 4; i++) if (lowest < 0 && m_ip[i] && m_im[i]) lowest = i;
      n_ip = m_ip;
      if (c_we) begin
         if (c_sel == 3'd0 && c_w == 5'd12) begin
            m_ie = c_din[0]; m_exl = c_din[1]; m_im = c_din[11:8];
         end else if (c_sel == 3'd0 && c_w == 5'd13) begin
            n_ip = c_din[11:8];
         end else if (c_sel == 3'd0 && c_w == 5'd14) begin
            m_epc = c_din;
         end else begin
            m_mem[c_sel][c_w] = c_din;
         end
      end
      if (c_take) begin
         m_epc = c_pc; m_exl = 1'b1; m_code = c_code;
         if (c_code == 5'd0 && lowest >= 0) n_ip[lowest] = 1'b0;
      end else if (c_eret) begin
         m_exl = 1'b0;
      end
      m_ip = n_ip | new_bits;
      m_irq_qd = m_irq_q;
      m_irq_q  = c_irq;
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, advance past the edge.
   task automatic drive(input logic c_clr, input logic c_we, input logic [2:0] c_sel,
                        input logic [4:0] c_r, input logic [4:0] c_w, input logic [31:0] c_din,
                        input logic c_take, input logic [4:0] c_code, input logic [31:0] c_pc,
                        input logic c_eret);
      exp_t e;
      clr = c_clr; WE = c_we; sel = c_sel; R_in = c_r; W_in = c_w; Din = c_din;
      irq = g_irq; exc_take = c_take; exc_code = c_code; exc_pc = c_pc; eret = c_eret;
      if (c_clr) model_zero();
      e.r_out   = model_read(c_sel, c_r);
      e.int_req = m_ie && !m_exl && ((m_ip & m_im) != 4'h0);
      e.epc     = m_epc;
      e.cyc     = cyc_no;
      exp_q.push_back(e);
      @(posedge clk);
      model_edge(c_clr, c_we, c_sel, c_w, c_din, g_irq, c_take, c_code, c_pc, c_eret);
      cyc_no++;
      #1;
   endtask

   task automatic rd(input logic [2:0] s, input logic [4:0] r);
      drive(1'b0, 1'b0, s, r, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
   endtask

   task automatic wr(input logic [2:0] s, input logic [4:0] w, input logic [31:0] d);
      drive(1'b0, 1'b1, s, w, w, d, 1'b0, 5'd0, 32'h0, 1'b0);
   endtask

   // Monitor: compares the DUT outputs of each driven cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (R_out !== e.r_out) begin
               failures++;
               $display("FAIL r_out cyc=%0d got=%h exp=%h", e.cyc, R_out, e.r_out);
            end
            checks++;
            if (int_req !== e.int_req) begin
               failures++;
               $display("FAIL int_req cyc=%0d got=%b exp=%b", e.cyc, int_req, e.int_req);
            end
            checks++;
            if (epc_out !== e.epc) begin
               failures++;
               $display("FAIL epc_out cyc=%0d got=%h exp=%h", e.cyc, epc_out, e.epc);
            end
            checks++;
            if (exc_vector !== 32'h0000_0080) begin
               failures++;
               $display("FAIL exc_vector cyc=%0d got=%h exp=%h", e.cyc, exc_vector, 32'h80);
            end
         end
      end
   end

   initial begin
      logic [2:0]  s;
      logic [4:0]  r, w, code;
      logic        we, tk, er, c;
      logic [31:0] d, pc;
      clr = 1'b1; WE = 0; sel = 0; R_in = 0; W_in = 0; Din = 0; irq = 0;
      exc_take = 0; exc_code = 0; exc_pc = 0; eret = 0;
      g_irq = 4'h0;
      model_zero();
      @(posedge clk);
      #1;

      // Reset state.
      drive(1'b1, 1'b0, 3'd0, 5'd12, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 3'd0, 5'd13, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      rd(3'd0, 5'd14);

      // General storage in a non-zero bank.
      wr(3'd5, 5'd3, 32'hDEAD_BEEF);
      rd(3'd5, 5'd3);
      rd(3'd0, 5'd3);
      wr(3'd2, 5'd12, 32'h5555_AAAA);
      rd(3'd2, 5'd12);
      rd(3'd0, 5'd12);

      // Interrupt enable and edge-set of IP.
      wr(3'd0, 5'd12, 32'h0000_0301);
      g_irq = 4'b0010;
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);
      g_irq = 4'b0110;
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);

      // Exception entry with interrupt code clears lowest pending enabled bit.
      g_irq = 4'b0111;
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);
      wr(3'd0, 5'd13, 32'h0000_0300);
      drive(1'b0, 1'b0, 3'd0, 5'd14, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0040_0010, 1'b0);
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd12);

      // ERET.
      drive(1'b0, 1'b0, 3'd0, 5'd12, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      rd(3'd0, 5'd12);
      rd(3'd0, 5'd14);

      // exc_take beats a same-cycle MTC0 to EPC; then exc_take again while EXL=1.
      drive(1'b0, 1'b1, 3'd0, 5'd14, 5'd14, 32'h0000_1234, 1'b1, 5'd12, 32'h0040_0020, 1'b0);
      rd(3'd0, 5'd14);
      rd(3'd0, 5'd13);
      drive(1'b0, 1'b1, 3'd0, 5'd12, 5'd12, 32'h0000_0F01, 1'b1, 5'd4, 32'h0040_0030, 1'b1);
      rd(3'd0, 5'd12);
      rd(3'd0, 5'd13);

      // clr mid-stream with irq high, then IP set two cycles after release.
      g_irq = 4'b1000;
      rd(3'd0, 5'd13);
      drive(1'b1, 1'b1, 3'd0, 5'd13, 5'd14, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h0BAD_0BAD, 1'b0);
      rd(3'd5, 5'd3);
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);
      rd(3'd0, 5'd13);

      // Randomised traffic biased toward the dedicated registers.
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 9) == 0) g_irq = 4'($urandom);
         s    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
         r    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 14)) : 5'($urandom);
         w    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 14)) : 5'($urandom);
         we   = ($urandom_range(0, 2) == 0);
         d    = $urandom;
         tk   = ($urandom_range(0, 7) == 0);
         code = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
         pc   = $urandom;
         er   = ($urandom_range(0, 7) == 0);
         c    = ($urandom_range(0, 59) == 0);
         drive(c, we, s, r, w, d, tk, code, pc, er);
      end

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0_exc.md
CP0_EXC -- requirements
Module: cp0_exc

Interface
REQ-001 Parameter WIDTH, default 32: data width of every CP0 register.
REQ-002 Parameter SEL_W, default 3: sel field width; 2**SEL_W register banks of 32 registers each.
REQ-003 Parameter NUM_IRQ, default 4, legal 1..8: number of hardware interrupt lines.
REQ-004 Parameter VECTOR, default 32'h0000_0080: exception handler address.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 clr  in  1  reset; asynchronous and active-high.
REQ-007 R_in  in  5  read register number.
REQ-008 W_in  in  5  write register number.
REQ-009 sel  in  SEL_W  bank select, used for both read and write.
REQ-010 Din  in  WIDTH  MTC0 write data.
REQ-011 WE  in  1  MTC0 write enable, active-high.
REQ-012 R_out  out  WIDTH  MFC0 read data.
REQ-013 irq  in  NUM_IRQ  level interrupt requests.
REQ-014 exc_take  in  1  pulse: the pipeline commits an exception this cycle.
REQ-015 exc_code  in  5  cause code for exc_take; 0 means interrupt.
REQ-016 exc_pc  in  WIDTH  PC to save on exc_take.
REQ-017 eret  in  1  pulse: the pipeline commits ERET this cycle.
REQ-018 int_req  out  1  interrupt pending toward the pipeline.
REQ-019 epc_out  out  WIDTH  current EPC, the ERET target.
REQ-020 exc_vector  out  WIDTH  constant VECTOR.

Function
REQ-021 The block SHALL hold 2**SEL_W x 32 general registers; R_out SHALL be the combinational read of (sel,R_in), 0 for out-of-range banks.
REQ-022 Bank 0 regs 12 (Status), 13 (Cause) and 14 (EPC) SHALL be dedicated registers returned on read in place of general storage.
REQ-023 Status SHALL use bit0=IE, bit1=EXL, bits[8+NUM_IRQ-1:8]=IM; Cause SHALL use bits[6:2]=ExcCode, bits[8+NUM_IRQ-1:8]=IP; all other bits SHALL read 0.
REQ-024 MTC0 to Status or EPC SHALL write the defined fields; MTC0 to Cause SHALL write only IP, so that software can clear pending bits.
REQ-025 irq SHALL be registered once (irq_q); an IP bit SHALL be set in the cycle after a 0->1 transition of irq_q. A set SHALL win over a simultaneous software clear.
REQ-026 int_req SHALL equal IE & ~EXL & |(IP & IM), combinationally from registered state.
REQ-027 On exc_take: EPC<=exc_pc, EXL<=1, ExcCode<=exc_code; if exc_code==0, the lowest-index bit of IP&IM SHALL be cleared.
REQ-028 On eret with no exc_take: EXL<=0; all other state is unchanged.
REQ-029 Same-cycle priority SHALL be clr > exc_take > eret > WE. If exc_take and WE both target Status/Cause/EPC, the exc_take field updates SHALL win and the other fields take the WE value.
REQ-030 exc_take while EXL=1 SHALL still overwrite EPC and ExcCode (no nesting stack).
REQ-031 epc_out SHALL equal EPC with zero latency; a write to EPC SHALL be visible on epc_out one cycle later.
REQ-032 A write to regs 12-14 in banks other than 0 SHALL go to general storage only.

Reset
REQ-033 clr=1 SHALL asynchronously zero all general registers, Status, Cause, EPC and irq_q, so that int_req=0 and epc_out=0. R_out SHALL follow the zeroed state.
REQ-034 clr asserted during an exc_take cycle SHALL leave all state zero; no partial capture is allowed.
REQ-035 After clr deasserts, an irq held high SHALL be treated as a new edge and set IP two cycles later.

Verification
REQ-036 Write bank 5 reg 3 = 32'hDEAD_BEEF, then read (5,3) -> R_out = DEAD_BEEF; read (0,3) -> 0.
REQ-037 Status = 32'h0000_0301, then raise irq[1] -> Cause.IP[9]=1 after 2 clocks and int_req=1 in the same cycle; irq[2] with IM[10]=0 -> int_req unchanged.
REQ-038 exc_take with exc_code=0, exc_pc=32'h0040_0010, IP=IM=10'b11_0000_0000 -> EPC = 0040_0010, EXL=1, IP[8] cleared, IP[9] kept, int_req=0.
REQ-039 eret after REQ-038 -> EXL=0, int_req=1 (IP[9] still set), epc_out = 0040_0010.
REQ-040 Same-cycle exc_take (code 12) with WE to EPC = 32'h1234 -> EPC = exc_pc and ExcCode = 12.
REQ-041 Assert clr mid-stream with irq high -> all outputs 0 at once; IP[n] set 2 cycles after clr falls.
